// File: rtl/sm_directory_multi.sv
// Multi-block directory controller: per-block DI/DS/DM state plus sharer vector, issues fetch/invalidate/reply messages.
// Latency: all messages registered, one cycle after acceptance; blocks owned by another processor take a two-cycle fetch.
// Backpressure: req_ready drops for the single FETCH cycle; a held request is accepted once the controller returns to IDLE.
module sm_directory_multi #(
   parameter int NUM_PROCS = 4,
   parameter int PROC_W    = 2,
   parameter int BLOCK_W   = 3
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [1:0]           req_type,
   input  logic [PROC_W-1:0]    req_proc,
   input  logic [BLOCK_W-1:0]   req_block,
   output logic                 resp_valid,
   output logic                 fetch,
   output logic [PROC_W-1:0]    fetch_proc,
   output logic                 invalidate_out,
   output logic [NUM_PROCS-1:0] invalidate_mask,
   output logic                 data_value_reply,
   output logic [PROC_W-1:0]    reply_proc,
   output logic                 proto_error,
   input  logic [BLOCK_W-1:0]   query_block,
   output logic [1:0]           query_state,
   output logic [NUM_PROCS-1:0] query_sharers
);

   localparam int NUM_BLOCKS = 2 ** BLOCK_W;

   localparam logic [1:0] READ_MISS  = 2'b00;
   localparam logic [1:0] WRITE_MISS = 2'b01;
   localparam logic [1:0] WRITE_BACK = 2'b10;

   typedef enum logic [1:0] {DI = 2'b00, DS = 2'b01, DM = 2'b10} dirState_t;
   typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} ctlState_t;

   // Committed directory table
   dirState_t            entryState   [NUM_BLOCKS];
   logic [NUM_PROCS-1:0] entrySharers [NUM_BLOCKS];

   ctlState_t ctlState;

   // Update held back until the end of the FETCH cycle
   logic [BLOCK_W-1:0]   pendBlock;
   logic [PROC_W-1:0]    pendProc;
   dirState_t            pendState;
   logic [NUM_PROCS-1:0] pendSharers;

   // Request decode
   dirState_t            curState;
   logic [NUM_PROCS-1:0] curSharers;
   logic [NUM_PROCS-1:0] procBit;
   logic [PROC_W-1:0]    ownerIdx;
   logic                 isOwner;
   logic                 procBad;
   logic                 isError;
   logic                 needFetch;
   logic                 doReply;
   dirState_t            nextState;
   logic [NUM_PROCS-1:0] nextSharers;
   logic [NUM_PROCS-1:0] invMask;
   logic                 accept;

   assign req_ready     = (ctlState == IDLE);
   assign accept        = req_valid && req_ready;
   assign query_state   = entryState[query_block];
   assign query_sharers = entrySharers[query_block];

   // Look up the addressed entry and work out the transition for the presented request
   always_comb begin
      curState    = entryState[req_block];
      curSharers  = entrySharers[req_block];
      procBit     = NUM_PROCS'(1) << req_proc;
      isOwner     = (curSharers & procBit) != '0;
      procBad     = int'(req_proc) >= NUM_PROCS;
      ownerIdx    = '0;
      for (int i = 0; i < NUM_PROCS; i++) begin
         if (curSharers[i]) ownerIdx = PROC_W'(i);
      end
      isError     = 1'b0;
      needFetch   = 1'b0;
      doReply     = 1'b0;
      nextState   = curState;
      nextSharers = curSharers;
      invMask     = '0;
      if (req_type == 2'b11 || procBad) begin
         isError = 1'b1;
      end else begin
         case (curState)
            DI: begin
               if (req_type == READ_MISS) begin
                  nextState   = DS;
                  nextSharers = procBit;
                  doReply     = 1'b1;
               end else if (req_type == WRITE_MISS) begin
                  nextState   = DM;
                  nextSharers = procBit;
                  doReply     = 1'b1;
               end else begin
                  isError = 1'b1;
               end
            end
            DS: begin
               if (req_type == READ_MISS) begin
                  nextSharers = curSharers | procBit;
                  doReply     = 1'b1;
               end else if (req_type == WRITE_MISS) begin
                  invMask     = curSharers & ~procBit;
                  nextState   = DM;
                  nextSharers = procBit;
                  doReply     = 1'b1;
               end else begin
                  isError = 1'b1;
               end
            end
            DM: begin
               if (isOwner) begin
                  // Owner may only write the block back; a miss from the owner is incoherent
                  if (req_type == WRITE_BACK) begin
                     nextState   = DI;
                     nextSharers = '0;
                  end else begin
                     isError = 1'b1;
                  end
               end else if (req_type == READ_MISS) begin
                  needFetch   = 1'b1;
                  nextState   = DS;
                  nextSharers = curSharers | procBit;
               end else if (req_type == WRITE_MISS) begin
                  needFetch   = 1'b1;
                  invMask     = curSharers;
                  nextState   = DM;
                  nextSharers = procBit;
               end else begin
                  isError = 1'b1;
               end
            end
            default: isError = 1'b1;
         endcase
      end
   end

   // Directory table: immediate commits on accept, deferred commit at the end of FETCH
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_BLOCKS; i++) begin
            entryState[i]   <= DI;
            entrySharers[i] <= '0;
         end
      end else if (ctlState == FETCH) begin
         entryState[pendBlock]   <= pendState;
         entrySharers[pendBlock] <= pendSharers;
      end else if (accept && !isError && !needFetch) begin
         entryState[req_block]   <= nextState;
         entrySharers[req_block] <= nextSharers;
      end
   end

   // Controller FSM with registered message outputs; every pulse defaults low each cycle
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ctlState         <= IDLE;
         pendBlock        <= '0;
         pendProc         <= '0;
         pendState        <= DI;
         pendSharers      <= '0;
         resp_valid       <= 1'b0;
         fetch            <= 1'b0;
         fetch_proc       <= '0;
         invalidate_out   <= 1'b0;
         invalidate_mask  <= '0;
         data_value_reply <= 1'b0;
         reply_proc       <= '0;
         proto_error      <= 1'b0;
      end else begin
         resp_valid       <= 1'b0;
         fetch            <= 1'b0;
         fetch_proc       <= '0;
         invalidate_out   <= 1'b0;
         invalidate_mask  <= '0;
         data_value_reply <= 1'b0;
         reply_proc       <= '0;
         proto_error      <= 1'b0;
         case (ctlState)
            IDLE: begin
               if (accept) begin
                  if (isError) begin
                     proto_error <= 1'b1;
                     resp_valid  <= 1'b1;
                  end else begin
                     if (invMask != '0) begin
                        invalidate_out  <= 1'b1;
                        invalidate_mask <= invMask;
                     end
                     if (needFetch) begin
                        ctlState    <= FETCH;
                        fetch       <= 1'b1;
                        fetch_proc  <= ownerIdx;
                        pendBlock   <= req_block;
                        pendProc    <= req_proc;
                        pendState   <= nextState;
                        pendSharers <= nextSharers;
                     end else begin
                        resp_valid <= 1'b1;
                        if (doReply) begin
                           data_value_reply <= 1'b1;
                           reply_proc       <= req_proc;
                        end
                     end
                  end
               end
            end
            FETCH: begin
               ctlState         <= IDLE;
               data_value_reply <= 1'b1;
               reply_proc       <= pendProc;
               resp_valid       <= 1'b1;
            end
            default: ctlState <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sm_directory_multi.sv
// Directed bench for sm_directory_multi (4 processors, 8 blocks).
// Each scenario task drives requests at posedge+1 and checks registered outputs one cycle later.
// pulses vector order: {resp_valid, fetch, invalidate_out, data_value_reply, proto_error}.
module tb_sm_directory_multi;

   logic       clock = 1'b0;
   logic       resetn;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_type;
   logic [1:0] req_proc;
   logic [2:0] req_block;
   logic       resp_valid;
   logic       fetch;
   logic [1:0] fetch_proc;
   logic       invalidate_out;
   logic [3:0] invalidate_mask;
   logic       data_value_reply;
   logic [1:0] reply_proc;
   logic       proto_error;
   logic [2:0] query_block;
   logic [1:0] query_state;
   logic [3:0] query_sharers;

   int errors = 0;
   int checks = 0;

   logic [4:0] pulses;
   logic [5:0] query;
   assign pulses = {resp_valid, fetch, invalidate_out, data_value_reply, proto_error};
   assign query  = {query_state, query_sharers};

   localparam logic [1:0] RM = 2'b00, WM = 2'b01, WB = 2'b10, RSV = 2'b11;

   sm_directory_multi #(.NUM_PROCS(4), .PROC_W(2), .BLOCK_W(3)) dut (
      .clock(clock), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
      .req_proc(req_proc), .req_block(req_block),
      .resp_valid(resp_valid), .fetch(fetch), .fetch_proc(fetch_proc),
      .invalidate_out(invalidate_out), .invalidate_mask(invalidate_mask),
      .data_value_reply(data_value_reply), .reply_proc(reply_proc),
      .proto_error(proto_error),
      .query_block(query_block), .query_state(query_state), .query_sharers(query_sharers)
   );

   always #5 clock = ~clock;

   task automatic drive(input logic v, input logic [1:0] t, input logic [1:0] p, input logic [2:0] b);
      req_valid = v;
      req_type  = t;
      req_proc  = p;
      req_block = b;
   endtask

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      drive(1'b0, RM, 2'd0, 3'd0);
      query_block = 3'd0;
      #3;
      checks++;
      if (pulses !== 5'b00000) begin errors++; $display("FAIL reset_pulses got=%b want=00000", pulses); end
      checks++;
      if ({fetch_proc, reply_proc, invalidate_mask} !== 8'h00) begin
         errors++; $display("FAIL reset_ids got=%h want=00", {fetch_proc, reply_proc, invalidate_mask});
      end
      step;
      step;
      resetn = 1'b1;
      step;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", req_ready); end
      for (int b = 0; b < 8; b++) begin
         query_block = 3'(b);
         step;
         checks++;
         if (query !== 6'b00_0000) begin errors++; $display("FAIL reset_query blk=%0d got=%b want=000000", b, query); end
      end
   endtask

   task automatic test_back_to_back;
      query_block = 3'd3;
      drive(1'b1, RM, 2'd0, 3'd3);
      step;
      checks++;
      if ({pulses, reply_proc} !== {5'b10010, 2'd0}) begin
         errors++; $display("FAIL b2b_rm0 got=%b/%0d want=10010/0", pulses, reply_proc);
      end
      drive(1'b1, RM, 2'd2, 3'd3);
      step;
      checks++;
      if ({pulses, reply_proc} !== {5'b10010, 2'd2}) begin
         errors++; $display("FAIL b2b_rm2 got=%b/%0d want=10010/2", pulses, reply_proc);
      end
      drive(1'b1, WM, 2'd1, 3'd3);
      step;
      checks++;
      if ({pulses, reply_proc, invalidate_mask} !== {5'b10110, 2'd1, 4'b0101}) begin
         errors++; $display("FAIL b2b_wm1 got=%b/%0d/%b want=10110/1/0101", pulses, reply_proc, invalidate_mask);
      end
      checks++;
      if (query !== 6'b10_0010) begin errors++; $display("FAIL b2b_query got=%b want=100010", query); end
      drive(1'b0, RM, 2'd0, 3'd0);
      step;
      checks++;
      if ({pulses, fetch_proc, reply_proc, invalidate_mask} !== 13'h0) begin
         errors++; $display("FAIL b2b_idle got=%b ids=%0d/%0d/%b want all 0", pulses, fetch_proc, reply_proc, invalidate_mask);
      end
   endtask

   task automatic test_fetch_read;
      query_block = 3'd5;
      drive(1'b1, WM, 2'd1, 3'd5);
      step;
      checks++;
      if ({pulses, reply_proc} !== {5'b10010, 2'd1}) begin
         errors++; $display("FAIL fr_setup got=%b/%0d want=10010/1", pulses, reply_proc);
      end
      drive(1'b1, RM, 2'd3, 3'd5);
      step;
      checks++;
      if ({pulses, fetch_proc, req_ready} !== {5'b01000, 2'd1, 1'b0}) begin
         errors++; $display("FAIL fr_fetch got=%b/%0d/rdy%b want=01000/1/rdy0", pulses, fetch_proc, req_ready);
      end
      checks++;
      if (query !== 6'b10_0010) begin errors++; $display("FAIL fr_query_pending got=%b want=100010", query); end
      drive(1'b0, RM, 2'd0, 3'd0);
      step;
      checks++;
      if ({pulses, reply_proc, req_ready} !== {5'b10010, 2'd3, 1'b1}) begin
         errors++; $display("FAIL fr_reply got=%b/%0d/rdy%b want=10010/3/rdy1", pulses, reply_proc, req_ready);
      end
      checks++;
      if (query !== 6'b01_1010) begin errors++; $display("FAIL fr_query got=%b want=011010", query); end
   endtask

   task automatic test_fetch_write;
      query_block = 3'd5;
      drive(1'b1, WM, 2'd3, 3'd5);
      step;
      checks++;
      if ({pulses, reply_proc, invalidate_mask} !== {5'b10110, 2'd3, 4'b0010}) begin
         errors++; $display("FAIL fw_own3 got=%b/%0d/%b want=10110/3/0010", pulses, reply_proc, invalidate_mask);
      end
      drive(1'b1, WM, 2'd0, 3'd5);
      step;
      checks++;
      if ({pulses, fetch_proc, invalidate_mask} !== {5'b01100, 2'd3, 4'b1000}) begin
         errors++; $display("FAIL fw_fetch got=%b/%0d/%b want=01100/3/1000", pulses, fetch_proc, invalidate_mask);
      end
      // writeBack held high through the FETCH cycle
      drive(1'b1, WB, 2'd0, 3'd5);
      step;
      checks++;
      if ({pulses, reply_proc, invalidate_mask} !== {5'b10010, 2'd0, 4'b0000}) begin
         errors++; $display("FAIL fw_reply got=%b/%0d/%b want=10010/0/0000", pulses, reply_proc, invalidate_mask);
      end
      checks++;
      if (query !== 6'b10_0001) begin errors++; $display("FAIL fw_query got=%b want=100001", query); end
      step;
      checks++;
      if (pulses !== 5'b10000) begin errors++; $display("FAIL fw_wb got=%b want=10000", pulses); end
      checks++;
      if (query !== 6'b00_0000) begin errors++; $display("FAIL fw_wb_query got=%b want=000000", query); end
      drive(1'b0, RM, 2'd0, 3'd0);
      step;
      checks++;
      if (pulses !== 5'b00000) begin errors++; $display("FAIL fw_idle got=%b want=00000", pulses); end
   endtask

   task automatic test_errors;
      logic [1:0] ty [4];
      logic [1:0] pr [4];
      ty = '{WM, RM, RSV, WB};
      pr = '{2'd1, 2'd1, 2'd2, 2'd2};
      query_block = 3'd0;
      drive(1'b1, WB, 2'd0, 3'd0);
      step;
      checks++;
      if ({pulses, fetch_proc, reply_proc, invalidate_mask} !== {5'b10001, 8'h00}) begin
         errors++; $display("FAIL err_wb_di got=%b ids=%0d/%0d/%b want=10001 ids 0", pulses, fetch_proc, reply_proc, invalidate_mask);
      end
      checks++;
      if (query !== 6'b00_0000) begin errors++; $display("FAIL err_wb_di_query got=%b want=000000", query); end
      query_block = 3'd3;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, ty[k], pr[k], 3'd3);
         step;
         checks++;
         if ({pulses, invalidate_mask} !== {5'b10001, 4'b0000}) begin
            errors++; $display("FAIL err_case%0d got=%b/%b want=10001/0000", k, pulses, invalidate_mask);
         end
         checks++;
         if (query !== 6'b10_0010) begin errors++; $display("FAIL err_case%0d_query got=%b want=100010", k, query); end
      end
      drive(1'b0, RM, 2'd0, 3'd0);
      step;
   endtask

   task automatic test_reset_mid_fetch;
      query_block = 3'd3;
      drive(1'b1, RM, 2'd0, 3'd3);
      step;
      checks++;
      if ({pulses, fetch_proc} !== {5'b01000, 2'd1}) begin
         errors++; $display("FAIL rmf_fetch got=%b/%0d want=01000/1", pulses, fetch_proc);
      end
      drive(1'b0, RM, 2'd0, 3'd0);
      resetn = 1'b0;
      #1;
      checks++;
      if ({pulses, fetch_proc} !== 7'h00) begin errors++; $display("FAIL rmf_async got=%b/%0d want=00000/0", pulses, fetch_proc); end
      step;
      resetn = 1'b1;
      step;
      checks++;
      if ({pulses, req_ready} !== 6'b000001) begin
         errors++; $display("FAIL rmf_after got=%b rdy=%b want=00000 rdy=1", pulses, req_ready);
      end
      checks++;
      if (query !== 6'b00_0000) begin errors++; $display("FAIL rmf_query got=%b want=000000", query); end
   endtask

   initial begin
      test_reset;
      test_back_to_back;
      test_fetch_read;
      test_fetch_write;
      test_errors;
      test_reset_mid_fetch;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
